// File: rtl/pixel_pkg.sv
// Shared definitions for the RGB565 un-blender: field positions, channel
// maxima, datapath widths, FSM state encoding and per-channel helpers.
package pixel_pkg;

    // RGB565 field positions
    localparam int R_HI = 15;
    localparam int R_LO = 11;
    localparam int G_HI = 10;
    localparam int G_LO = 5;
    localparam int B_HI = 4;
    localparam int B_LO = 0;

    // Channel maxima
    localparam logic [4:0] R_MAX = 5'd31;
    localparam logic [5:0] G_MAX = 6'd63;
    localparam logic [4:0] B_MAX = 5'd31;

    // Datapath widths
    localparam int DIV_W  = 14;
    localparam int FACT_W = 8;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_DIV_R = 3'd2,
        ST_DIV_G = 3'd3,
        ST_DIV_B = 3'd4,
        ST_PACK  = 3'd5,
        ST_DONE  = 3'd6
    } unblend_state_t;

    // Rounded dividend for one channel: N = c_out*255 - c_a*(255-f), floored
    // at zero; a positive N gets f/2 added so the later floor division rounds.
    // The largest positive result is 63*255 + 127 = 16192, inside 14 bits.
    function automatic logic [DIV_W-1:0] prep_dividend(
        input logic [5:0]        c_out,
        input logic [5:0]        c_a,
        input logic [FACT_W-1:0] f
    );
        logic [15:0]        p_out;
        logic [15:0]        p_a;
        logic signed [15:0] n;
        p_out = {10'd0, c_out} * 16'd255;
        p_a   = {10'd0, c_a} * {8'd0, (8'd255 - f)};
        n     = signed'(p_out - p_a);
        if (n <= 16'sd0) begin
            prep_dividend = 14'd0;
        end else begin
            prep_dividend = n[DIV_W-1:0] + {7'd0, f[FACT_W-1:1]};
        end
    endfunction

    // Saturate a quotient into a 5-bit channel
    function automatic logic [4:0] sat_5bit(
        input logic [DIV_W-1:0] q,
        input logic [4:0]       cmax
    );
        if (q > {9'd0, cmax}) begin
            sat_5bit = cmax;
        end else begin
            sat_5bit = q[4:0];
        end
    endfunction

    // Saturate a quotient into a 6-bit channel
    function automatic logic [5:0] sat_6bit(
        input logic [DIV_W-1:0] q,
        input logic [5:0]       cmax
    );
        if (q > {8'd0, cmax}) begin
            sat_6bit = cmax;
        end else begin
            sat_6bit = q[5:0];
        end
    endfunction

endpackage

// File: rtl/unblend_divider.sv
// Sequential restoring divider: 14-bit dividend by 8-bit divisor, one quotient
// bit per cycle, MSB first. A start pulse loads the operands; done pulses on
// the 14th iteration cycle with the final quotient presented on the same cycle.
module unblend_divider
    import pixel_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DIV_W-1:0]  dividend,
    input  logic [FACT_W-1:0] divisor,
    output logic              done,
    output logic [DIV_W-1:0]  quotient
);

    localparam logic [3:0] LAST_ITER = 4'd13;

    logic [FACT_W-1:0] rem_r;
    logic [FACT_W-1:0] dsr_r;
    logic [DIV_W-1:0]  quo_r;
    logic [3:0]        cnt_r;
    logic              busy_r;

    logic [FACT_W:0]   shifted_s;
    logic [FACT_W-1:0] rem_next_s;
    logic [DIV_W-1:0]  quo_next_s;
    logic              last_s;

    // One restoring step: shift in the next dividend bit and try a subtract
    always_comb begin
        shifted_s = {rem_r, quo_r[DIV_W-1]};
        if (shifted_s >= {1'b0, dsr_r}) begin
            rem_next_s = shifted_s[FACT_W-1:0] - dsr_r;
            quo_next_s = {quo_r[DIV_W-2:0], 1'b1};
        end else begin
            rem_next_s = shifted_s[FACT_W-1:0];
            quo_next_s = {quo_r[DIV_W-2:0], 1'b0};
        end
    end

    assign last_s   = busy_r && (cnt_r == LAST_ITER);
    assign done     = last_s;
    assign quotient = quo_next_s;

    // Operand load on start, then iterate until the last quotient bit is formed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_r  <= '0;
            dsr_r  <= '0;
            quo_r  <= '0;
            cnt_r  <= 4'd0;
            busy_r <= 1'b0;
        end else if (start) begin
            rem_r  <= '0;
            dsr_r  <= divisor;
            quo_r  <= dividend;
            cnt_r  <= 4'd0;
            busy_r <= 1'b1;
        end else if (busy_r) begin
            rem_r  <= rem_next_s;
            quo_r  <= quo_next_s;
            cnt_r  <= cnt_r + 4'd1;
            busy_r <= !last_s;
        end else begin
            busy_r <= 1'b0;
        end
    end

endmodule

// File: rtl/image_unblender.sv
// Recovers the layer-B RGB565 pixel from a blended pixel, the known layer-A
// pixel and the blend factor. The three channels share one serial divider,
// giving one result every 47 cycles plus the output handshake.
module image_unblender
    import pixel_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       blended_in,
    input  logic [15:0]       image_a,
    input  logic [FACT_W-1:0] blend_factor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       image_b_out,
    output logic              div_zero
);

    unblend_state_t    state_r;
    unblend_state_t    state_next_s;

    logic [15:0]       blend_r;
    logic [15:0]       a_r;
    logic [FACT_W-1:0] f_r;

    logic [DIV_W-1:0]  dvd_red_r;
    logic [DIV_W-1:0]  dvd_grn_r;
    logic [DIV_W-1:0]  dvd_blu_r;

    logic [4:0]        q_red_r;
    logic [5:0]        q_grn_r;
    logic [4:0]        q_blu_r;

    logic              launch_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [15:0]       pix_r;
    logic              dz_r;

    logic              accept_s;
    logic              consume_s;
    logic              f_zero_s;
    logic [DIV_W-1:0]  div_dividend_s;
    logic              div_done_s;
    logic [DIV_W-1:0]  div_quotient_s;

    assign accept_s  = in_valid && in_ready_r;
    assign consume_s = (state_r == ST_DONE) && out_ready;
    assign f_zero_s  = (f_r == 8'd0);

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign image_b_out = pix_r;
    assign div_zero    = dz_r;

    // Next-state logic for the accept / prepare / divide x3 / pack / hand-off sequence
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_PREP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PREP: begin
                if (f_zero_s) begin
                    state_next_s = ST_PACK;
                end else begin
                    state_next_s = ST_DIV_R;
                end
            end
            ST_DIV_R: begin
                if (div_done_s) begin
                    state_next_s = ST_DIV_G;
                end else begin
                    state_next_s = ST_DIV_R;
                end
            end
            ST_DIV_G: begin
                if (div_done_s) begin
                    state_next_s = ST_DIV_B;
                end else begin
                    state_next_s = ST_DIV_G;
                end
            end
            ST_DIV_B: begin
                if (div_done_s) begin
                    state_next_s = ST_PACK;
                end else begin
                    state_next_s = ST_DIV_B;
                end
            end
            ST_PACK: begin
                state_next_s = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Route the dividend of the channel currently being divided
    always_comb begin
        div_dividend_s = 14'd0;
        case (state_r)
            ST_DIV_R: div_dividend_s = dvd_red_r;
            ST_DIV_G: div_dividend_s = dvd_grn_r;
            ST_DIV_B: div_dividend_s = dvd_blu_r;
            default:  div_dividend_s = 14'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Divider start pulse: on entry to each channel's divide state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            launch_r <= 1'b0;
        end else begin
            launch_r <= ((state_r == ST_PREP) && !f_zero_s) ||
                        (div_done_s && ((state_r == ST_DIV_R) || (state_r == ST_DIV_G)));
        end
    end

    // Capture the input triple on accept; later stages only use these copies
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blend_r <= 16'h0000;
            a_r     <= 16'h0000;
            f_r     <= 8'd0;
        end else if (accept_s) begin
            blend_r <= blended_in;
            a_r     <= image_a;
            f_r     <= blend_factor;
        end
    end

    // Per-channel rounded dividends, registered during PREP
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dvd_red_r <= 14'd0;
            dvd_grn_r <= 14'd0;
            dvd_blu_r <= 14'd0;
        end else if (state_r == ST_PREP) begin
            dvd_red_r <= prep_dividend({1'b0, blend_r[R_HI:R_LO]}, {1'b0, a_r[R_HI:R_LO]}, f_r);
            dvd_grn_r <= prep_dividend(blend_r[G_HI:G_LO], a_r[G_HI:G_LO], f_r);
            dvd_blu_r <= prep_dividend({1'b0, blend_r[B_HI:B_LO]}, {1'b0, a_r[B_HI:B_LO]}, f_r);
        end
    end

    // Saturated channel quotients, taken when the divider reports done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_red_r <= 5'd0;
            q_grn_r <= 6'd0;
            q_blu_r <= 5'd0;
        end else if (div_done_s) begin
            case (state_r)
                ST_DIV_R: q_red_r <= sat_5bit(div_quotient_s, R_MAX);
                ST_DIV_G: q_grn_r <= sat_6bit(div_quotient_s, G_MAX);
                ST_DIV_B: q_blu_r <= sat_5bit(div_quotient_s, B_MAX);
                default:  q_red_r <= q_red_r;
            endcase
        end
    end

    // Input handshake: low from accept until the result has been consumed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready_r <= 1'b1;
        end else if (accept_s) begin
            in_ready_r <= 1'b0;
        end else if (consume_s) begin
            in_ready_r <= 1'b1;
        end
    end

    // Output registers: loaded in PACK, held through DONE until consumed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            pix_r       <= 16'h0000;
            dz_r        <= 1'b0;
        end else if (state_r == ST_PACK) begin
            out_valid_r <= 1'b1;
            dz_r        <= f_zero_s;
            if (f_zero_s) begin
                pix_r <= 16'h0000;
            end else begin
                pix_r <= {q_red_r, q_grn_r, q_blu_r};
            end
        end else if (consume_s) begin
            out_valid_r <= 1'b0;
        end
    end

    unblend_divider u_divider (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (launch_r),
        .dividend (div_dividend_s),
        .divisor  (f_r),
        .done     (div_done_s),
        .quotient (div_quotient_s)
    );

endmodule
